// File: rtl/avalon_packet_sf_fifo_pkg.sv
// Shared types and helpers for the store-and-forward packet FIFO.
//   fifo_in_sm_t : input-side state machine encoding
//   empty_w()    : width of the Avalon-ST empty field for a given bytes/beat
package avalon_packet_sf_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STORE,
      DISCARD
   } fifo_in_sm_t;

   // A 1-byte bus still carries a 1-bit empty field so that the port never
   // collapses to zero width.
   function automatic int empty_w(input int bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/avalon_packet_sf_fifo_if.sv
// Avalon-ST packet interface.
//   master : drives data, empty, valid, sop, eop; receives rdy
//   slave  : receives data, empty, valid, sop, eop; drives rdy
interface avalon_st_if
   import avalon_packet_sf_fifo_pkg::*;
#(
   parameter int DATA_WIDTH_IN_BYTES = 16
) ();
   localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
   localparam int EW = empty_w(DATA_WIDTH_IN_BYTES);

   logic [DW-1:0] data;
   logic [EW-1:0] empty;
   logic          valid;
   logic          sop;
   logic          eop;
   logic          rdy;

   modport master (output data, empty, valid, sop, eop, input rdy);
   modport slave  (input data, empty, valid, sop, eop, output rdy);
endinterface

// File: rtl/avalon_packet_sf_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// read (data appears the cycle after re_i).
//   clk      : clock
//   we_i     : write enable, waddr_i / wdata_i
//   re_i     : read enable, raddr_i
//   rdata_o  : read data, valid one cycle after re_i
module sdp_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/avalon_packet_sf_fifo.sv
// Store-and-forward packet FIFO. Whole packets are buffered and released
// only once their eop is stored; a packet that does not fit is dropped
// whole. The input is never back-pressured.
//   clk, rst        : clock, synchronous active-high reset
//   msg_in          : packet stream in (rdy tied high)
//   msg_out         : complete packets out
//   packet_dropped  : one-cycle pulse per discarded input packet
//   fifo_full       : stored beats == DEPTH
//   packets_stored  : committed packets not yet fully read out
//
// Input state machine:
//   state   | meaning
//   IDLE    | waiting for sop; non-sop beats ignored
//   STORE   | writing the body of an accepted packet
//   DISCARD | dropping the rest of a packet until its eop
module avalon_packet_sf_fifo
   import avalon_packet_sf_fifo_pkg::*;
#(
   parameter int DATA_WIDTH_IN_BYTES = 16,
   parameter int DEPTH               = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   avalon_st_if.slave             msg_in,
   avalon_st_if.master            msg_out,
   output logic                   packet_dropped,
   output logic                   fifo_full,
   output logic [$clog2(DEPTH):0] packets_stored
);
   localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
   localparam int EW = empty_w(DATA_WIDTH_IN_BYTES);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef struct packed {
      logic [DW-1:0] data;
      logic [EW-1:0] empty;
      logic          eop;
   } entry_t;
   localparam int ENTRY_W = $bits(entry_t);

   fifo_in_sm_t state_q, state_d;
   ptr_t wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
   // rd_ptr retires beats on output acceptance; fetch_ptr runs ahead into
   // the skid. Space is freed only by rd_ptr so skid beats stay counted.
   ptr_t rd_ptr_q, rd_ptr_d, fetch_ptr_q;
   ptr_t used_q, used_d, pkts_q, pkts_d;
   logic dropped_q, full_q;
   logic wr_en, commit, drop, rewind, space;

   entry_t wr_entry, ram_rd, skid0_q, skid1_q, head, cand1;
   logic [ENTRY_W-1:0] ram_rdata;
   logic [1:0] skid_cnt_q, avail, remain;
   logic rvalid_q, sop_pend_q, out_valid, pop, issue;

   // ---------------- input side ----------------
   assign used_q = wr_ptr_q - rd_ptr_q;
   assign space  = (used_q != ptr_t'(DEPTH));
   assign wr_entry = {msg_in.data, msg_in.empty, msg_in.eop};

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      commit  = 1'b0;
      drop    = 1'b0;
      rewind  = 1'b0;
      case (state_q)
         IDLE: begin
            if (msg_in.valid && msg_in.sop) begin
               if (space) begin
                  wr_en = 1'b1;
                  if (msg_in.eop) commit = 1'b1;
                  else            state_d = STORE;
               end else begin
                  drop = 1'b1;
                  if (!msg_in.eop) state_d = DISCARD;
               end
            end
         end
         STORE: begin
            if (msg_in.valid) begin
               if (space) begin
                  wr_en = 1'b1;
                  if (msg_in.eop) begin
                     commit  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  drop    = 1'b1;
                  rewind  = 1'b1;
                  state_d = msg_in.eop ? IDLE : DISCARD;
               end
            end
         end
         DISCARD: begin
            if (msg_in.valid && msg_in.eop) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      wr_ptr_d     = rewind ? commit_ptr_q : wr_ptr_q + ptr_t'(wr_en);
      commit_ptr_d = commit ? wr_ptr_q + ptr_t'(1) : commit_ptr_q;
      rd_ptr_d     = rd_ptr_q + ptr_t'(pop);
      used_d       = wr_ptr_d - rd_ptr_d;

      pkts_d = pkts_q;
      if (commit && !(pop && head.eop))      pkts_d = pkts_q + ptr_t'(1);
      else if (!commit && pop && head.eop)   pkts_d = pkts_q - ptr_t'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         pkts_q       <= '0;
         dropped_q    <= 1'b0;
         full_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pkts_q       <= pkts_d;
         dropped_q    <= drop;
         full_q       <= (used_d == ptr_t'(DEPTH));
      end
   end

   sdp_ram #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wr_entry),
      .re_i    (issue),
      .raddr_i (fetch_ptr_q[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   // ---------------- output side ----------------
   // Beats available this cycle are the skid contents followed by the RAM
   // read data (if a read was issued last cycle). The RAM data is presented
   // directly when the skid is empty, saving a cycle of latency.
   assign ram_rd    = ram_rdata;
   assign avail     = skid_cnt_q + {1'b0, rvalid_q};
   assign out_valid = (avail != 2'd0);
   assign head      = (skid_cnt_q == 2'd0) ? ram_rd : skid0_q;
   assign cand1     = (skid_cnt_q == 2'd1) ? ram_rd : skid1_q;
   assign pop       = out_valid & msg_out.rdy;
   assign remain    = avail - {1'b0, pop};
   // Only fetch when the skid can absorb the result next cycle.
   assign issue     = (fetch_ptr_q != commit_ptr_q) && (remain < 2'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         skid0_q     <= '0;
         skid1_q     <= '0;
         skid_cnt_q  <= 2'd0;
         rvalid_q    <= 1'b0;
         sop_pend_q  <= 1'b1;
         fetch_ptr_q <= '0;
      end else begin
         rvalid_q <= issue;
         if (issue) fetch_ptr_q <= fetch_ptr_q + ptr_t'(1);
         if (pop) begin
            skid0_q    <= cand1;
            skid_cnt_q <= remain;
            sop_pend_q <= head.eop;
         end else begin
            skid0_q    <= head;
            skid1_q    <= cand1;
            skid_cnt_q <= avail;
         end
      end
   end

   assign msg_in.rdy    = 1'b1;
   assign msg_out.valid = out_valid;
   assign msg_out.sop   = out_valid & sop_pend_q;
   assign msg_out.eop   = out_valid & head.eop;
   assign msg_out.empty = (out_valid && head.eop) ? head.empty : '0;
   assign msg_out.data  = out_valid ? head.data : '0;

   assign packet_dropped = dropped_q;
   assign fifo_full      = full_q;
   assign packets_stored = pkts_q;
endmodule

// File: tb/tb_avalon_packet_sf_fifo.sv
module tb_avalon_packet_sf_fifo;
   localparam int NB    = 16;
   localparam int DEPTH = 64;

   typedef struct packed {
      logic         sop;
      logic         eop;
      logic [3:0]   empty;
      logic [127:0] data;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       packet_dropped;
   logic       fifo_full;
   logic [6:0] packets_stored;

   avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) in_if ();
   avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) out_if ();

   avalon_packet_sf_fifo #(.DATA_WIDTH_IN_BYTES(NB), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .msg_in         (in_if),
      .msg_out        (out_if),
      .packet_dropped (packet_dropped),
      .fifo_full      (fifo_full),
      .packets_stored (packets_stored)
   );

   always #5 clk = ~clk;

   int    checks    = 0;
   int    failures  = 0;
   beat_t exp_q[$];
   int    last_acc  = 0;
   int    drop_cnt  = 0;
   int    drop_beat = 0;
   int    out_beats = 0;
   bit    full_seen = 1'b0;
   bit    hold_q    = 1'b0;
   beat_t hold_v;
   bit    mon_t5    = 1'b0;
   int    t5_beats  = 0;
   int    t5_gaps   = 0;
   int    t5_sops   = 0;
   int    t5_eops   = 0;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor / scoreboard consumer, sampled away from the rising edge.
   always @(negedge clk) begin
      beat_t cur, e;
      if (rst) begin
         hold_q = 1'b0;
      end else begin
         cur = {out_if.sop, out_if.eop, out_if.empty, out_if.data};
         if (hold_q) begin
            check("hold_valid", out_if.valid, 1'b1);
            check("hold_beat", cur, hold_v);
         end
         if (packet_dropped) begin
            drop_cnt++;
            drop_beat = last_acc;
         end
         if (fifo_full) full_seen = 1'b1;
         if (mon_t5 && !out_if.valid && t5_beats > 0 && t5_beats < 100) t5_gaps++;
         if (out_if.valid && out_if.rdy) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_beat", cur, e);
            end
            out_beats++;
            if (mon_t5) begin
               t5_beats++;
               if (out_if.sop) t5_sops++;
               if (out_if.eop) t5_eops++;
            end
         end
         hold_q = out_if.valid && !out_if.rdy;
         hold_v = cur;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_if.valid = 1'b0;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
   endtask

   // Drives a packet back-to-back; non-eop beats carry empty=F to show it is masked.
   task automatic send_pkt(input int len, input logic [127:0] base, input logic [3:0] emp, input bit keep);
      beat_t b;
      for (int i = 1; i <= len; i++) begin
         in_if.valid = 1'b1;
         in_if.sop   = (i == 1);
         in_if.eop   = (i == len);
         in_if.data  = base + 128'(i - 1);
         in_if.empty = (i == len) ? emp : 4'hF;
         if (keep) begin
            b.sop   = (i == 1);
            b.eop   = (i == len);
            b.empty = (i == len) ? emp : 4'h0;
            b.data  = base + 128'(i - 1);
            exp_q.push_back(b);
         end
         cycle();
         last_acc = i;
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) cycle();
      cycle();
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, b0;
      in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
      in_if.data  = '0;   in_if.empty = '0;
      out_if.rdy  = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset values
      @(negedge clk);
      check("rst_valid",   out_if.valid, 1'b0);
      check("rst_sop",     out_if.sop, 1'b0);
      check("rst_eop",     out_if.eop, 1'b0);
      check("rst_empty",   out_if.empty, 4'h0);
      check("rst_data",    out_if.data, 128'h0);
      check("rst_dropped", packet_dropped, 1'b0);
      check("rst_full",    fifo_full, 1'b0);
      check("rst_stored",  packets_stored, 7'd0);
      check("in_rdy",      in_if.rdy, 1'b1);

      // 3-beat packet, latency and packet count
      out_if.rdy = 1'b1;
      cycle();
      send_pkt(3, 128'h1, 4'd5, 1'b1);
      idle();
      @(negedge clk);
      check("t1_n1_valid", out_if.valid, 1'b0);
      check("t1_stored_1", packets_stored, 7'd1);
      @(negedge clk);
      check("t1_n2_valid", out_if.valid, 1'b1);
      check("t1_n2_sop",   out_if.sop, 1'b1);
      cycle();
      drain("t1_drain");
      check("t1_stored_0", packets_stored, 7'd0);

      // 60-beat packet then 10-beat packet with rdy=0: second dropped on beat 5
      out_if.rdy = 1'b0;
      d0 = drop_cnt;
      send_pkt(60, 128'h2000, 4'd3, 1'b1);
      send_pkt(10, 128'h3000, 4'd7, 1'b0);
      idle();
      cycle(); cycle();
      check("t2_drop_count", drop_cnt - d0, 1);
      check("t2_drop_beat",  drop_beat, 5);
      check("t2_stored_1",   packets_stored, 7'd1);
      check("t2_full_after", fifo_full, 1'b0);
      out_if.rdy = 1'b1;
      drain("t2_drain");
      check("t2_stored_0",   packets_stored, 7'd0);

      // 65-beat packet into an empty buffer
      full_seen = 1'b0;
      d0 = drop_cnt;
      b0 = out_beats;
      send_pkt(65, 128'h4000, 4'd0, 1'b0);
      idle();
      repeat (6) cycle();
      check("t3_drop_count", drop_cnt - d0, 1);
      check("t3_drop_beat",  drop_beat, 65);
      check("t3_full_seen",  full_seen, 1'b1);
      check("t3_full_after", fifo_full, 1'b0);
      check("t3_no_output",  out_beats - b0, 0);
      check("t3_stored",     packets_stored, 7'd0);

      // rdy toggling 1,0,0,1 on a 4-beat packet
      out_if.rdy = 1'b0;
      b0 = out_beats;
      send_pkt(4, 128'h5000, 4'd9, 1'b1);
      idle();
      for (int i = 0; i < 10 && !out_if.valid; i++) cycle();
      check("t4_valid_seen", out_if.valid, 1'b1);
      out_if.rdy = 1'b1; cycle();
      out_if.rdy = 1'b0; cycle(); cycle();
      out_if.rdy = 1'b1;
      drain("t4_drain");
      check("t4_beats", out_beats - b0, 4);

      // 20 back-to-back 5-beat packets, wraps the buffer
      mon_t5 = 1'b1;
      for (int p = 0; p < 20; p++)
         send_pkt(5, 128'h10000 + 128'(p * 256), 4'(p % 16), 1'b1);
      idle();
      drain("t5_drain");
      mon_t5 = 1'b0;
      check("t5_beats", t5_beats, 100);
      check("t5_gaps",  t5_gaps, 0);
      check("t5_sops",  t5_sops, 20);
      check("t5_eops",  t5_eops, 20);

      // reset mid-packet with two committed packets pending
      out_if.rdy = 1'b0;
      send_pkt(3, 128'h6000, 4'd1, 1'b1);
      send_pkt(3, 128'h6100, 4'd2, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         in_if.valid = 1'b1;
         in_if.sop   = (i == 1);
         in_if.eop   = 1'b0;
         in_if.data  = 128'h6200 + 128'(i);
         in_if.empty = 4'h0;
         cycle();
         last_acc = i;
      end
      idle();
      check("t6_stored_2", packets_stored, 7'd2);
      d0 = drop_cnt;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("t6_valid", out_if.valid, 1'b0);
      check("t6_stored_0", packets_stored, 7'd0);
      check("t6_full", fifo_full, 1'b0);
      check("t6_no_drop", drop_cnt - d0, 0);
      out_if.rdy = 1'b1;
      cycle();
      send_pkt(3, 128'h7000, 4'd4, 1'b1);
      idle();
      drain("t6_drain");
      check("t6_stored_end", packets_stored, 7'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
